// File: rtl/alu_pkg.sv
// Shared encodings for the argon multi-cycle ALU: bus commands, opcodes,
// flag bit positions and the multiplier sequencer states.
package alu_pkg;

  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    LATCH_A  = 4'd1,
    LATCH_B  = 4'd2,
    LATCH_F  = 4'd3,
    LATCH_OP = 4'd4,
    START    = 4'd5,
    OUT_Y    = 4'd6,
    OUT_H    = 4'd7,
    OUT_F    = 4'd8
  } cmd_t;

  // Codes 15..31 are reserved and behave as no-ops on START.
  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,
    OP_ADC  = 5'd1,
    OP_SBC  = 5'd2,
    OP_INC  = 5'd3,
    OP_DEC  = 5'd4,
    OP_NAND = 5'd5,
    OP_AND  = 5'd6,
    OP_OR   = 5'd7,
    OP_NOR  = 5'd8,
    OP_XOR  = 5'd9,
    OP_LSH  = 5'd10,
    OP_RSH  = 5'd11,
    OP_ASR  = 5'd12,
    OP_CMP  = 5'd13,
    OP_MUL  = 5'd14
  } op_t;

  localparam int unsigned FLAG_W     = 8;
  localparam int unsigned F_CARRY    = 0;
  localparam int unsigned F_ZERO     = 1;
  localparam int unsigned F_EQUAL    = 2;
  localparam int unsigned F_GREATER  = 3;
  localparam int unsigned F_LESS     = 4;
  localparam int unsigned F_OVF      = 5;
  localparam int unsigned F_SGREATER = 6;
  localparam int unsigned F_SLESS    = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/argon_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles of accumulation followed by a one-cycle DONE state.
module argon_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   product_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  mul_state_t           state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 busy_q;
  logic                 done_q;

  // Sequencer: snapshot operands on start, accumulate WIDTH cycles, flag done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            prod_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (mplier_q[0]) begin
            prod_q <= prod_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign product_o = prod_q;

endmodule

// File: rtl/argon_alu_mc.sv
// Bus-controlled ALU: operand/flag/opcode latches, single-cycle ALU ops and
// an iterative multiplier that holds the bus busy while it runs.
module argon_alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_Clk,
  input  logic             i_Reset_n,
  input  logic             i_valid,
  input  logic [3:0]       i_command,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_busy
);

  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, y_q, y_d, h_q, h_d;
  logic [FLAG_W-1:0]  f_q, f_d;
  logic [4:0]         op_q, op_d;

  cmd_t               cmd;
  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  logic [WIDTH:0]     alu_r;
  logic [WIDTH-1:0]   alu_bb, alu_y;
  logic [FLAG_W-1:0]  alu_f;
  logic [SHW-1:0]     alu_sh;
  logic               alu_add, alu_sub, alu_cmp, alu_ok, alu_cin;

  assign cmd       = cmd_t'(i_command);
  assign accept    = i_valid && !mul_busy;
  assign mul_start = accept && (cmd == START) && (op_q == OP_MUL);
  assign o_busy    = mul_busy;

  argon_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (i_Clk),
    .rst_ni   (i_Reset_n),
    .start_i  (mul_start),
    .a_i      (a_q),
    .b_i      (b_q),
    .busy_o   (mul_busy),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  // Single-cycle datapath on WIDTH+1 bits; bit WIDTH is carry/borrow.
  always_comb begin
    alu_r   = '0;
    alu_bb  = b_q;
    alu_add = 1'b0;
    alu_sub = 1'b0;
    alu_cmp = 1'b0;
    alu_ok  = 1'b1;
    alu_cin = f_q[F_CARRY];
    alu_sh  = b_q[SHW-1:0];
    alu_y   = y_q;
    alu_f   = '0;
    case (op_t'(op_q))
      OP_ADD:  begin alu_r = {1'b0, a_q} + {1'b0, b_q}; alu_add = 1'b1; end
      OP_ADC:  begin
        alu_r   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, alu_cin};
        alu_add = 1'b1;
      end
      OP_SBC:  begin
        alu_r   = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, alu_cin};
        alu_sub = 1'b1;
      end
      OP_INC:  begin
        alu_bb  = WIDTH'(1);
        alu_r   = {1'b0, a_q} + (WIDTH+1)'(1);
        alu_add = 1'b1;
      end
      OP_DEC:  begin
        alu_bb  = WIDTH'(1);
        alu_r   = {1'b0, a_q} - (WIDTH+1)'(1);
        alu_sub = 1'b1;
      end
      OP_NAND: alu_r = {1'b0, ~(a_q & b_q)};
      OP_AND:  alu_r = {1'b0, a_q & b_q};
      OP_OR:   alu_r = {1'b0, a_q | b_q};
      OP_NOR:  alu_r = {1'b0, ~(a_q | b_q)};
      OP_XOR:  alu_r = {1'b0, a_q ^ b_q};
      OP_LSH:  alu_r = {1'b0, a_q} << alu_sh;
      OP_RSH:  alu_r = {1'b0, a_q >> alu_sh};
      OP_ASR:  alu_r = {1'b0, $unsigned($signed(a_q) >>> alu_sh)};
      OP_CMP:  alu_cmp = 1'b1;
      default: alu_ok = 1'b0;
    endcase

    if (alu_cmp) begin
      alu_f[F_CARRY]    = f_q[F_CARRY];
      alu_f[F_ZERO]     = (a_q == b_q);
      alu_f[F_EQUAL]    = (a_q == b_q);
      alu_f[F_GREATER]  = (a_q > b_q);
      alu_f[F_LESS]     = (a_q < b_q);
      alu_f[F_SGREATER] = ($signed(a_q) > $signed(b_q));
      alu_f[F_SLESS]    = ($signed(a_q) < $signed(b_q));
    end else begin
      alu_y          = alu_r[WIDTH-1:0];
      alu_f[F_CARRY] = alu_r[WIDTH];
      alu_f[F_ZERO]  = (alu_r[WIDTH-1:0] == '0);
      alu_f[F_OVF]   = (alu_add && (a_q[WIDTH-1] == alu_bb[WIDTH-1])
                                && (alu_r[WIDTH-1] != a_q[WIDTH-1]))
                    || (alu_sub && (a_q[WIDTH-1] != alu_bb[WIDTH-1])
                                && (alu_r[WIDTH-1] != a_q[WIDTH-1]));
    end
  end

  // Register next-state: bus writes when idle, multiplier result on done.
  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    f_d  = f_q;
    op_d = op_q;
    y_d  = y_q;
    h_d  = h_q;
    if (accept) begin
      case (cmd)
        LATCH_A:  a_d  = i_data;
        LATCH_B:  b_d  = i_data;
        LATCH_F:  f_d  = i_data[FLAG_W-1:0];
        LATCH_OP: op_d = i_data[4:0];
        START: begin
          if (alu_ok) begin
            y_d = alu_y;
            f_d = alu_f;
            h_d = '0;
          end
        end
        default: ;
      endcase
    end
    if (mul_done) begin
      y_d            = mul_prod[WIDTH-1:0];
      h_d            = mul_prod[2*WIDTH-1:WIDTH];
      f_d            = '0;
      f_d[F_CARRY]   = (mul_prod[2*WIDTH-1:WIDTH] != '0);
      f_d[F_ZERO]    = (mul_prod == '0);
    end
  end

  // Architectural state registers.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      f_q  <= '0;
      op_q <= '0;
      y_q  <= '0;
      h_q  <= '0;
    end else begin
      a_q  <= a_d;
      b_q  <= b_d;
      f_q  <= f_d;
      op_q <= op_d;
      y_q  <= y_d;
      h_q  <= h_d;
    end
  end

  // Read port: Y/H withheld while the multiplier runs, flags always readable.
  always_comb begin
    o_valid = 1'b0;
    o_data  = '0;
    if (i_Reset_n && i_valid) begin
      case (cmd)
        OUT_Y: if (!mul_busy) begin o_valid = 1'b1; o_data = y_q; end
        OUT_H: if (!mul_busy) begin o_valid = 1'b1; o_data = h_q; end
        OUT_F: begin
          o_valid = 1'b1;
          o_data  = {{(WIDTH-FLAG_W){1'b0}}, f_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_argon_alu_mc.sv
// Bench for argon_alu_mc at WIDTH=16: directed vector table, hand-written
// multiplier/reset sequences and a random command stream against a model.
module tb_argon_alu_mc;
  import alu_pkg::*;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [3:0]    i_command = 4'd0;
  logic [W-1:0]  i_data = '0;
  logic [W-1:0]  o_data;
  logic          o_valid;
  logic          o_busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic obs_busy;

  argon_alu_mc #(.WIDTH(W), .SHW(4)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_valid(i_valid), .i_command(i_command),
    .i_data(i_data), .o_data(o_data), .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [15:0] m_a, m_b, m_y, m_h;
  logic [7:0]  m_f;
  logic [4:0]  m_op;
  int          m_left;
  logic [15:0] p_y, p_h;
  logic [7:0]  p_f;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sx(input int v);
    return (v & 'h8000) != 0 ? v - 65536 : v;
  endfunction

  task automatic model_reset();
    m_a = '0; m_b = '0; m_y = '0; m_h = '0; m_f = '0; m_op = '0; m_left = 0;
  endtask

  task automatic model_start();
    int a, b, sa, sb, cin, s, ss, sh;
    logic c, ov;
    logic [7:0] nf;
    longint p;
    a = int'(m_a); b = int'(m_b); sa = sx(a); sb = sx(b);
    cin = int'(m_f[F_CARRY]); sh = b % 16;
    s = 0; ss = 0; c = 0; ov = 0;
    case (m_op)
      OP_ADD:  begin s = a + b;       ss = sa + sb;       c = s > 65535; end
      OP_ADC:  begin s = a + b + cin; ss = sa + sb + cin; c = s > 65535; end
      OP_SBC:  begin s = a - b - cin; ss = sa - sb - cin; c = s < 0; end
      OP_INC:  begin s = a + 1;       ss = sa + 1;        c = s > 65535; end
      OP_DEC:  begin s = a - 1;       ss = sa - 1;        c = s < 0; end
      OP_NAND: s = ~(a & b);
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_NOR:  s = ~(a | b);
      OP_XOR:  s = a ^ b;
      OP_LSH:  begin s = a << sh; c = ((s >> 16) & 1) != 0; end
      OP_RSH:  s = a >> sh;
      OP_ASR:  s = sa >>> sh;
      default: ;
    endcase
    if (m_op inside {OP_ADD, OP_ADC, OP_SBC, OP_INC, OP_DEC})
      ov = (ss > 32767) || (ss < -32768);
    if (m_op == OP_CMP) begin
      nf = '0;
      nf[F_CARRY]    = m_f[F_CARRY];
      nf[F_ZERO]     = (a == b);
      nf[F_EQUAL]    = (a == b);
      nf[F_GREATER]  = (a > b);
      nf[F_LESS]     = (a < b);
      nf[F_SGREATER] = (sa > sb);
      nf[F_SLESS]    = (sa < sb);
      m_f = nf; m_h = '0;
    end else if (m_op == OP_MUL) begin
      p = longint'(a) * longint'(b);
      p_y = 16'(p & 'hFFFF);
      p_h = 16'((p >> 16) & 'hFFFF);
      p_f = '0;
      p_f[F_CARRY] = (p_h != 0);
      p_f[F_ZERO]  = (p == 0);
      m_left = W + 1;
    end else if (m_op <= 5'd13) begin
      m_y = 16'(s & 'hFFFF);
      m_h = '0;
      nf = '0;
      nf[F_CARRY] = c;
      nf[F_ZERO]  = (m_y == 0);
      nf[F_OVF]   = ov;
      m_f = nf;
    end
  endtask

  // One bus cycle: drive at negedge, check all outputs, advance model at posedge.
  task automatic bus(input logic [3:0] c, input logic [15:0] d, input logic v,
                     output logic [15:0] rd, output logic rv);
    logic acc, ev;
    logic [15:0] ed;
    @(negedge clk);
    i_valid = v; i_command = c; i_data = d;
    #1;
    acc = v && (m_left == 0);
    ev = 1'b0; ed = '0;
    if (v) begin
      if (c == OUT_Y && m_left == 0) begin ev = 1'b1; ed = m_y; end
      if (c == OUT_H && m_left == 0) begin ev = 1'b1; ed = m_h; end
      if (c == OUT_F) begin ev = 1'b1; ed = {8'h00, m_f}; end
    end
    rd = o_data; rv = o_valid; obs_busy = o_busy;
    chk("busy", o_busy, m_left > 0);
    chk("valid", o_valid, ev);
    chk("data", o_data, ed);
    @(posedge clk);
    #1;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_y = p_y; m_h = p_h; m_f = p_f; end
    end else if (acc) begin
      case (c)
        LATCH_A:  m_a = d;
        LATCH_B:  m_b = d;
        LATCH_F:  m_f = d[7:0];
        LATCH_OP: m_op = d[4:0];
        START:    model_start();
        default: ;
      endcase
    end
    i_valid = 1'b0; i_command = 4'd0;
  endtask

  task automatic cmd(input logic [3:0] c, input logic [15:0] d);
    logic [15:0] rd; logic rv;
    bus(c, d, 1'b1, rd, rv);
  endtask

  task automatic rdv(input logic [3:0] c, output logic [15:0] rd, output logic rv);
    bus(c, 16'h0000, 1'b1, rd, rv);
  endtask

  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 100 && m_left > 0; k++) begin
      cmd(CMD_NOP, 16'h0000);
      if (obs_busy) busy_cycles++;
    end
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [15:0] a, b;
    logic [7:0]  fin;
    logic [15:0] y, h;
    logic [7:0]  f;
  } vec_t;

  vec_t vt[14];

  task automatic setv(input int i, input logic [4:0] op, input logic [15:0] a, b,
                      input logic [7:0] fin, input logic [15:0] y, h, input logic [7:0] f);
    vt[i].op = op; vt[i].a = a; vt[i].b = b; vt[i].fin = fin;
    vt[i].y = y; vt[i].h = h; vt[i].f = f;
  endtask

  initial begin
    logic [15:0] rd;
    logic rv;
    int nb;
    logic [3:0] rc;
    logic [15:0] rdat;
    logic rvld;

    model_reset();
    // Vectors run in order: CMP/reserved rows rely on Y from the row before.
    setv(0,  OP_ADD, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 16'h0000, 8'h03);
    setv(1,  OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 16'h0000, 8'h20);
    setv(2,  OP_CMP, 16'h8000, 16'h0001, 8'h01, 16'h8000, 16'h0000, 8'h89);
    setv(3,  OP_MUL, 16'h1234, 16'h0100, 8'h00, 16'h3400, 16'h0012, 8'h01);
    setv(4,  OP_ASR, 16'h8010, 16'h0004, 8'h00, 16'hF801, 16'h0000, 8'h00);
    setv(5,  5'h1F,  16'h1111, 16'h2222, 8'hA5, 16'hF801, 16'h0000, 8'hA5);
    setv(6,  OP_ADC, 16'h0001, 16'h0002, 8'h01, 16'h0004, 16'h0000, 8'h00);
    setv(7,  OP_SBC, 16'h0000, 16'h0000, 8'h01, 16'hFFFF, 16'h0000, 8'h01);
    setv(8,  OP_DEC, 16'h8000, 16'h0000, 8'h00, 16'h7FFF, 16'h0000, 8'h20);
    setv(9,  OP_LSH, 16'h8001, 16'h0001, 8'h00, 16'h0002, 16'h0000, 8'h01);
    setv(10, OP_NOR, 16'h0000, 16'h0000, 8'h00, 16'hFFFF, 16'h0000, 8'h00);
    setv(11, OP_XOR, 16'h5555, 16'h5555, 8'h00, 16'h0000, 16'h0000, 8'h02);
    setv(12, OP_CMP, 16'h1234, 16'h1234, 8'h00, 16'h0000, 16'h0000, 8'h06);
    setv(13, OP_MUL, 16'h0000, 16'h1234, 8'h00, 16'h0000, 16'h0000, 8'h02);

    // Outputs held quiet during reset even with a read requested
    i_valid = 1'b1; i_command = OUT_F;
    #3;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valid", o_valid, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; i_valid = 1'b0; i_command = 4'd0;

    rdv(OUT_Y, rd, rv); chk("rst_Y", rd, 16'h0000); chk("rst_Yv", rv, 1'b1);
    rdv(OUT_F, rd, rv); chk("rst_F", rd, 16'h0000);

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      cmd(LATCH_A, vt[i].a);
      cmd(LATCH_B, vt[i].b);
      cmd(LATCH_F, {8'h00, vt[i].fin});
      cmd(LATCH_OP, {11'h000, vt[i].op});
      cmd(START, 16'h0000);
      wait_idle(nb);
      if (vt[i].op == OP_MUL) chk("mul_busy_cycles", nb, W + 1);
      else chk("single_busy_cycles", nb, 0);
      rdv(OUT_Y, rd, rv); chk($sformatf("vec%0d_Y", i), rd, vt[i].y);
      rdv(OUT_H, rd, rv); chk($sformatf("vec%0d_H", i), rd, vt[i].h);
      rdv(OUT_F, rd, rv); chk($sformatf("vec%0d_F", i), rd, {8'h00, vt[i].f});
    end

    // Multiplier ignores bus writes and restarts while busy
    cmd(LATCH_A, 16'h1234); cmd(LATCH_B, 16'h0100); cmd(LATCH_OP, OP_MUL);
    cmd(START, 16'h0000);
    rdv(OUT_Y, rd, rv); chk("busy_outY_valid", rv, 1'b0); chk("busy_outY_data", rd, 16'h0000);
    rdv(OUT_F, rd, rv); chk("busy_outF_valid", rv, 1'b1);
    cmd(LATCH_A, 16'hAAAA);
    cmd(START, 16'h0000);
    wait_idle(nb);
    chk("busy_tail_cycles", nb, W + 1 - 4);
    cmd(CMD_NOP, 16'h0000);
    chk("no_restart", obs_busy, 1'b0);
    rdv(OUT_Y, rd, rv); chk("hold_Y", rd, 16'h3400);
    rdv(OUT_H, rd, rv); chk("hold_H", rd, 16'h0012);
    cmd(LATCH_OP, OP_OR); cmd(LATCH_B, 16'h0000); cmd(START, 16'h0000);
    rdv(OUT_Y, rd, rv); chk("A_preserved", rd, 16'h1234);

    // Reset in the middle of a multiply
    cmd(LATCH_A, 16'h1234); cmd(LATCH_B, 16'h0100); cmd(LATCH_OP, OP_MUL);
    cmd(START, 16'h0000);
    repeat (8) cmd(CMD_NOP, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0; i_valid = 1'b1; i_command = OUT_F;
    #1;
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_valid", o_valid, 1'b0);
    chk("abort_data", o_data, 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1; i_valid = 1'b0; i_command = 4'd0;
    rdv(OUT_Y, rd, rv); chk("abort_Y", rd, 16'h0000);
    rdv(OUT_H, rd, rv); chk("abort_H", rd, 16'h0000);
    rdv(OUT_F, rd, rv); chk("abort_F", rd, 16'h0000);
    cmd(LATCH_A, 16'h0003); cmd(LATCH_B, 16'h0005); cmd(LATCH_OP, OP_MUL);
    cmd(START, 16'h0000);
    wait_idle(nb);
    chk("remul_cycles", nb, W + 1);
    rdv(OUT_Y, rd, rv); chk("remul_Y", rd, 16'h000F);
    rdv(OUT_F, rd, rv); chk("remul_F", rd, 16'h0000);

    // Random command stream against the model
    for (int i = 0; i < 600; i++) begin
      rc = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rc = START;
      if (rc == LATCH_OP) rdat = 16'($urandom_range(0, 31));
      else rdat = 16'($urandom);
      bus(rc, rdat, $urandom_range(0, 7) != 0, rd, rvld);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
